coalesce_request_scheduler: RTL

Shares one coalesce_splitter between NumRequesters load/store requesters (e.g. per-warp issue slots) in the load/store unit. Round-robin arbitration selects a requester, a free common request tag is allocated and sent with the request to the splitter, and per-tag pending thread masks are tracked against memory responses. When every thread of a request has been served, the block reports completion with requester index and tag, then frees the tag.

---
 rtl/load_store_pkg.sv | 30 +++
 rtl/coalesce_tag_table.sv | 104 ++++++++++
 rtl/coalesce_request_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/load_store_pkg.sv
// Shared types and sizing for the load/store unit coalescing scheduler.
//   NumRequesters    : requester ports sharing one splitter
//   NumRequests      : threads per request (warp width)
//   AddressWidth     : address bits per thread
//   NumTags          : outstanding common request tags
//   TagWidth         : splitter CommonReqIdWidth
//   RequesterIdWidth : width of a requester index
package load_store_pkg;

  localparam int unsigned NumRequesters    = 2;
  localparam int unsigned NumRequests      = 4;
  localparam int unsigned AddressWidth     = 32;
  localparam int unsigned NumTags          = 4;
  localparam int unsigned TagWidth         = (NumTags > 1) ? $clog2(NumTags) : 1;
  localparam int unsigned RequesterIdWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

  typedef enum logic [1:0] {
    TAG_FREE     = 2'd0,
    TAG_PENDING  = 2'd1,
    TAG_COMPLETE = 2'd2
  } tag_state_e;

  typedef struct packed {
    tag_state_e                    state;
    logic [NumRequests-1:0]        mask;
    logic [RequesterIdWidth-1:0]   requester;
    logic                          we;
  } tag_entry_t;

endpackage

// File: rtl/coalesce_tag_table.sv
// Per-tag bookkeeping for outstanding coalesced requests.
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   alloc_*               : claim a FREE tag with the granted request's mask/owner/we
//   rsp_valid_i/tag/mask  : memory response clearing served threads of a tag
//   done_ack_i            : reported COMPLETE tag is consumed and returns to FREE
//   free_valid_o/tag_o    : lowest-index FREE tag (combinational from state)
//   done_*_o              : lowest-index COMPLETE tag and its owner/we (combinational)
//   rsp_err_o             : response addressed to a tag that is not PENDING
module coalesce_tag_table
  import load_store_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        alloc_i,
  input  logic [TagWidth-1:0]         alloc_tag_i,
  input  logic [NumRequests-1:0]      alloc_mask_i,
  input  logic [RequesterIdWidth-1:0] alloc_requester_i,
  input  logic                        alloc_we_i,
  input  logic                        rsp_valid_i,
  input  logic [TagWidth-1:0]         rsp_tag_i,
  input  logic [NumRequests-1:0]      rsp_mask_i,
  input  logic                        done_ack_i,
  output logic                        free_valid_o,
  output logic [TagWidth-1:0]         free_tag_o,
  output logic                        done_valid_o,
  output logic [TagWidth-1:0]         done_tag_o,
  output logic [RequesterIdWidth-1:0] done_requester_o,
  output logic                        done_we_o,
  output logic                        rsp_err_o
);

  tag_entry_t             r_entry      [NumTags];
  tag_entry_t             w_entry_next [NumTags];
  logic [NumRequests-1:0] w_mask_left  [NumTags];

  // Next-state per tag; a pending tag completes on the edge its mask reaches zero
  always_comb begin
    for (int t = 0; t < NumTags; t++) begin
      w_entry_next[t] = r_entry[t];
      w_mask_left[t]  = r_entry[t].mask;
      case (r_entry[t].state)
        TAG_FREE: begin
          if (alloc_i && (alloc_tag_i == TagWidth'(t))) begin
            w_entry_next[t].state     = TAG_PENDING;
            w_entry_next[t].mask      = alloc_mask_i;
            w_entry_next[t].requester = alloc_requester_i;
            w_entry_next[t].we        = alloc_we_i;
          end
        end
        TAG_PENDING: begin
          if (rsp_valid_i && (rsp_tag_i == TagWidth'(t))) begin
            w_mask_left[t] = r_entry[t].mask & ~rsp_mask_i;
          end
          w_entry_next[t].mask = w_mask_left[t];
          if (w_mask_left[t] == '0) begin
            w_entry_next[t].state = TAG_COMPLETE;
          end
        end
        TAG_COMPLETE: begin
          if (done_ack_i && (done_tag_o == TagWidth'(t))) begin
            w_entry_next[t].state = TAG_FREE;
          end
        end
        default: w_entry_next[t].state = TAG_FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < NumTags; t++) begin
        r_entry[t] <= '{state: TAG_FREE, mask: '0, requester: '0, we: 1'b0};
      end
    end else begin
      for (int t = 0; t < NumTags; t++) begin
        r_entry[t] <= w_entry_next[t];
      end
    end
  end

  // Lowest-index finders: scan high to low so the lowest match is written last
  always_comb begin
    free_valid_o = 1'b0;
    free_tag_o   = '0;
    done_valid_o = 1'b0;
    done_tag_o   = '0;
    for (int t = NumTags - 1; t >= 0; t--) begin
      if (r_entry[t].state == TAG_FREE) begin
        free_valid_o = 1'b1;
        free_tag_o   = TagWidth'(t);
      end
      if (r_entry[t].state == TAG_COMPLETE) begin
        done_valid_o = 1'b1;
        done_tag_o   = TagWidth'(t);
      end
    end
  end

  assign done_requester_o = r_entry[done_tag_o].requester;
  assign done_we_o        = r_entry[done_tag_o].we;
  assign rsp_err_o        = rsp_valid_i && (r_entry[rsp_tag_i].state != TAG_PENDING);

endmodule

// File: rtl/coalesce_request_scheduler.sv
// Round-robin sharing of one coalesce_splitter between requesters, with
// common-tag allocation and completion reporting.
// Ports:
//   clk_i, rst_i            : clock, async active-high reset
//   req_*                   : per-requester valid/we/thread mask/addresses; req_ready_o one-hot accept
//   spl_*                   : request to the splitter (combinational from the granted requester)
//   rsp_valid_i/tag/mask    : memory response serving threads of a tag
//   done_*                  : completion report (lowest COMPLETE tag), consumed by done_ready_i
module coalesce_request_scheduler
  import load_store_pkg::*;
(
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic [NumRequesters-1:0]                       req_valid_i,
  output logic [NumRequesters-1:0]                       req_ready_o,
  input  logic [NumRequesters-1:0]                       req_we_i,
  input  logic [NumRequesters*NumRequests-1:0]           req_addr_valid_i,
  input  logic [NumRequesters*NumRequests*AddressWidth-1:0] req_addr_i,
  output logic                                           spl_valid_o,
  input  logic                                           spl_ready_i,
  output logic                                           spl_we_o,
  output logic [TagWidth-1:0]                            spl_req_id_o,
  output logic [NumRequests-1:0]                         spl_addr_valid_o,
  output logic [NumRequests*AddressWidth-1:0]            spl_addr_o,
  input  logic                                           rsp_valid_i,
  input  logic [TagWidth-1:0]                            rsp_tag_i,
  input  logic [NumRequests-1:0]                         rsp_mask_i,
  output logic                                           done_valid_o,
  input  logic                                           done_ready_i,
  output logic [TagWidth-1:0]                            done_tag_o,
  output logic [RequesterIdWidth-1:0]                    done_requester_o,
  output logic                                           done_we_o
);

  localparam int unsigned RidSumWidth = RequesterIdWidth + 1;
  localparam int unsigned LaneBits    = NumRequests * AddressWidth;

  logic [RequesterIdWidth-1:0] r_rr_ptr;
  logic [RequesterIdWidth-1:0] w_grant;
  logic [RequesterIdWidth-1:0] w_cand;
  logic [RequesterIdWidth-1:0] w_rr_next;
  logic [RidSumWidth-1:0]      w_sum;
  logic [RidSumWidth-1:0]      w_next_sum;
  logic                        w_any_req;
  logic                        w_free_valid;
  logic [TagWidth-1:0]         w_free_tag;
  logic                        w_alloc;
  logic                        w_done_ack;
  logic                        w_rsp_err;
  logic [NumRequests-1:0]      w_mask_arr [NumRequesters];
  logic [LaneBits-1:0]         w_addr_arr [NumRequesters];

  // Round-robin pick: walk from farthest to nearest offset so the nearest valid wins
  always_comb begin
    w_grant   = '0;
    w_any_req = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = NumRequesters - 1; k >= 0; k--) begin
      w_sum = RidSumWidth'(r_rr_ptr) + RidSumWidth'(k);
      if (w_sum >= RidSumWidth'(NumRequesters)) begin
        w_sum = w_sum - RidSumWidth'(NumRequesters);
      end
      w_cand = RequesterIdWidth'(w_sum);
      if (req_valid_i[w_cand]) begin
        w_any_req = 1'b1;
        w_grant   = w_cand;
      end
    end
  end

  assign w_next_sum = RidSumWidth'(w_grant) + RidSumWidth'(1);
  assign w_rr_next  = (w_next_sum >= RidSumWidth'(NumRequesters)) ? '0
                                                                  : RequesterIdWidth'(w_next_sum);

  // Split the flat requester buses into per-requester lanes
  always_comb begin
    for (int r = 0; r < NumRequesters; r++) begin
      w_mask_arr[r] = req_addr_valid_i[r*NumRequests +: NumRequests];
      w_addr_arr[r] = req_addr_i[r*LaneBits +: LaneBits];
    end
  end

  assign spl_valid_o      = w_any_req && w_free_valid && !rst_i;
  assign w_alloc          = spl_valid_o && spl_ready_i;
  assign spl_we_o         = req_we_i[w_grant];
  assign spl_req_id_o     = w_free_tag;
  assign spl_addr_valid_o = w_mask_arr[w_grant];
  assign spl_addr_o       = w_addr_arr[w_grant];

  always_comb begin
    req_ready_o = '0;
    if (w_alloc) begin
      req_ready_o[w_grant] = 1'b1;
    end
  end

  // Pointer advances only on a splitter handshake so an unaccepted grant stays put
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_alloc) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  assign w_done_ack = done_valid_o && done_ready_i;

  coalesce_tag_table u_tag_table (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .alloc_i           (w_alloc),
    .alloc_tag_i       (w_free_tag),
    .alloc_mask_i      (spl_addr_valid_o),
    .alloc_requester_i (w_grant),
    .alloc_we_i        (spl_we_o),
    .rsp_valid_i       (rsp_valid_i),
    .rsp_tag_i         (rsp_tag_i),
    .rsp_mask_i        (rsp_mask_i),
    .done_ack_i        (w_done_ack),
    .free_valid_o      (w_free_valid),
    .free_tag_o        (w_free_tag),
    .done_valid_o      (done_valid_o),
    .done_tag_o        (done_tag_o),
    .done_requester_o  (done_requester_o),
    .done_we_o         (done_we_o),
    .rsp_err_o         (w_rsp_err)
  );

  // Responses to tags that are not pending are dropped; flag them in simulation
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!w_rsp_err)
        else $warning("response to non-pending tag %0d ignored", rsp_tag_i);
    end
  end

endmodule
